// File: rtl/ex_stage.sv
// ex_stage: execute stage of the 5-stage pipeline.
// Latches decode outputs on PIPELINE_READY and computes single-cycle ALU results
// combinationally from the latched operands. It also owns the HI/LO registers.
// MULT/MULTU/DIV/DIVU run through an iterative engine: a radix-2 restoring divider
// and a shift-add multiplier that share the same registers. PIPELINE_VALID is held
// low while the engine is busy.
// Optional build macro: EX_HW_MUL_EN. When it is defined, MULT/MULTU use a
// combinational multiplier and complete in a single cycle.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | no multi-cycle op in flight; result valid
// BUSY  | MULT/DIV iterating, one step per cycle; result not valid
// DONE  | HI/LO written by the engine; valid, waiting for the next op
module ex_stage #(
   parameter int DIV_CYCLES = 32
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        PIPELINE_FLUSH,
   input  logic        PIPELINE_READY,
   output logic        PIPELINE_VALID,
   input  logic [4:0]  alu_op_i,
   input  logic [31:0] src_a_i,
   input  logic [31:0] src_b_i,
   input  logic [31:0] rt_data_i,
   input  logic        s_reg_write_i,
   input  logic [4:0]  s_reg_write_dst_i,
   input  logic        s_mem_read_i,
   input  logic        s_mem_write_i,
   input  logic        s_mem_half_i,
   output logic [31:0] ex_result,
   output logic [31:0] rt_bypass,
   output logic        s_reg_write,
   output logic        s_mem_read,
   output logic        s_mem_write,
   output logic        s_mem_half,
   output logic [4:0]  s_reg_write_dst
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_BUSY = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   localparam logic [4:0] OP_ADD   = 5'd0;
   localparam logic [4:0] OP_SUB   = 5'd1;
   localparam logic [4:0] OP_AND   = 5'd2;
   localparam logic [4:0] OP_OR    = 5'd3;
   localparam logic [4:0] OP_XOR   = 5'd4;
   localparam logic [4:0] OP_NOR   = 5'd5;
   localparam logic [4:0] OP_SLT   = 5'd6;
   localparam logic [4:0] OP_SLTU  = 5'd7;
   localparam logic [4:0] OP_SLL   = 5'd8;
   localparam logic [4:0] OP_SRL   = 5'd9;
   localparam logic [4:0] OP_SRA   = 5'd10;
   localparam logic [4:0] OP_LUI   = 5'd11;
   localparam logic [4:0] OP_MFHI  = 5'd12;
   localparam logic [4:0] OP_MFLO  = 5'd13;
   localparam logic [4:0] OP_MTHI  = 5'd14;
   localparam logic [4:0] OP_MTLO  = 5'd15;
   localparam logic [4:0] OP_MULT  = 5'd16;
   localparam logic [4:0] OP_MULTU = 5'd17;
   localparam logic [4:0] OP_DIV   = 5'd18;
   localparam logic [4:0] OP_DIVU  = 5'd19;

   localparam logic [4:0] CNT_LAST = 5'(DIV_CYCLES - 1);

   logic [4:0]  op_q;
   logic [31:0] a_q, b_q;
   logic [31:0] hi, lo;
   logic [1:0]  state;
   logic [4:0]  cnt;

   // Engine registers: acc is the upper product word or the partial remainder,
   // sh is the multiplier/low product word or the dividend/quotient shift register.
   logic [31:0] acc, sh, opd;
   logic [31:0] nxt_acc, nxt_sh;
   logic [32:0] sum33, trial, diff;
   logic        ge;

   logic        start_md;
   logic        in_signed, in_div;
   logic [31:0] mag_a, mag_b;
   logic        is_div_q, signed_q;
   logic [63:0] prod_it;
   logic [31:0] fin_hi, fin_lo;

`ifdef EX_HW_MUL_EN
   logic [63:0] prod_s, prod_u;
   assign prod_s   = 64'($signed(a_q)) * 64'($signed(b_q));
   assign prod_u   = {32'd0, a_q} * {32'd0, b_q};
   assign start_md = (alu_op_i == OP_DIV) || (alu_op_i == OP_DIVU);
`else
   assign start_md = (alu_op_i >= OP_MULT) && (alu_op_i <= OP_DIVU);
`endif

   assign in_signed = ~alu_op_i[0];
   assign in_div    = alu_op_i[1];
   assign mag_a     = (in_signed && src_a_i[31]) ? (32'd0 - src_a_i) : src_a_i;
   assign mag_b     = (in_signed && src_b_i[31]) ? (32'd0 - src_b_i) : src_b_i;
   assign is_div_q  = op_q[1];
   assign signed_q  = ~op_q[0];

   assign PIPELINE_VALID = (state != S_BUSY);

   // Input latches: advance on READY, flush squashes op and control to a NOP.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         op_q            <= '0;
         a_q             <= '0;
         b_q             <= '0;
         rt_bypass       <= '0;
         s_reg_write     <= 1'b0;
         s_reg_write_dst <= '0;
         s_mem_read      <= 1'b0;
         s_mem_write     <= 1'b0;
         s_mem_half      <= 1'b0;
      end else if (PIPELINE_READY) begin
         if (PIPELINE_FLUSH) begin
            op_q            <= OP_ADD;
            a_q             <= '0;
            b_q             <= '0;
            rt_bypass       <= '0;
            s_reg_write     <= 1'b0;
            s_reg_write_dst <= '0;
            s_mem_read      <= 1'b0;
            s_mem_write     <= 1'b0;
            s_mem_half      <= 1'b0;
         end else begin
            op_q            <= alu_op_i;
            a_q             <= src_a_i;
            b_q             <= src_b_i;
            rt_bypass       <= rt_data_i;
            s_reg_write     <= s_reg_write_i;
            s_reg_write_dst <= s_reg_write_dst_i;
            s_mem_read      <= s_mem_read_i;
            s_mem_write     <= s_mem_write_i;
            s_mem_half      <= s_mem_half_i;
         end
      end
   end

   // One engine step: shift-add for multiply, restoring subtract for divide.
   always_comb begin
      sum33   = {1'b0, acc} + {1'b0, (sh[0] ? opd : 32'd0)};
      trial   = {acc, sh[31]};
      diff    = trial - {1'b0, opd};
      ge      = (trial >= {1'b0, opd});
      nxt_acc = sum33[32:1];
      nxt_sh  = {sum33[0], sh[31:1]};
      if (is_div_q) begin
         nxt_acc = ge ? diff[31:0] : trial[31:0];
         nxt_sh  = {sh[30:0], ge};
      end
   end

   // Sign fix and divide-by-zero handling applied on the final step.
   always_comb begin
      prod_it = {nxt_acc, nxt_sh};
      fin_hi  = nxt_acc;
      fin_lo  = nxt_sh;
      if (is_div_q) begin
         if (b_q == 32'd0) begin
            fin_hi = a_q;
            fin_lo = 32'hFFFF_FFFF;
         end else if (signed_q) begin
            if (a_q[31] ^ b_q[31]) fin_lo = 32'd0 - nxt_sh;
            if (a_q[31])           fin_hi = 32'd0 - nxt_acc;
         end
      end else if (signed_q && (a_q[31] ^ b_q[31])) begin
         {fin_hi, fin_lo} = 64'd0 - prod_it;
      end
   end

   // Sequencing FSM and iteration counter; engine loads from the inputs at latch time.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= S_IDLE;
         cnt   <= '0;
         acc   <= '0;
         sh    <= '0;
         opd   <= '0;
      end else if (PIPELINE_READY) begin
         cnt <= '0;
         if (!PIPELINE_FLUSH && start_md) begin
            state <= S_BUSY;
            acc   <= '0;
            sh    <= in_div ? mag_a : mag_b;
            opd   <= in_div ? mag_b : mag_a;
         end else begin
            state <= S_IDLE;
         end
      end else if (state == S_BUSY) begin
         acc <= nxt_acc;
         sh  <= nxt_sh;
         if (cnt == CNT_LAST) state <= S_DONE;
         else                 cnt   <= cnt + 5'd1;
      end
   end

   // HI/LO: engine result on the last step, otherwise single-cycle moves (and HW multiply).
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hi <= '0;
         lo <= '0;
      end else if (state == S_BUSY) begin
         if (!PIPELINE_READY && cnt == CNT_LAST) begin
            hi <= fin_hi;
            lo <= fin_lo;
         end
      end else begin
         case (op_q)
            OP_MTHI:  hi <= a_q;
            OP_MTLO:  lo <= a_q;
`ifdef EX_HW_MUL_EN
            OP_MULT:  {hi, lo} <= prod_s;
            OP_MULTU: {hi, lo} <= prod_u;
`endif
            default: ;
         endcase
      end
   end

   // Single-cycle ALU result from the latched operands.
   always_comb begin
      ex_result = 32'd0;
      case (op_q)
         OP_ADD:  ex_result = a_q + b_q;
         OP_SUB:  ex_result = a_q - b_q;
         OP_AND:  ex_result = a_q & b_q;
         OP_OR:   ex_result = a_q | b_q;
         OP_XOR:  ex_result = a_q ^ b_q;
         OP_NOR:  ex_result = ~(a_q | b_q);
         OP_SLT:  ex_result = {31'd0, ($signed(a_q) < $signed(b_q))};
         OP_SLTU: ex_result = {31'd0, (a_q < b_q)};
         OP_SLL:  ex_result = b_q << a_q[4:0];
         OP_SRL:  ex_result = b_q >> a_q[4:0];
         OP_SRA:  ex_result = $unsigned($signed(b_q) >>> a_q[4:0]);
         OP_LUI:  ex_result = {b_q[15:0], 16'h0000};
         OP_MFHI: ex_result = hi;
         OP_MFLO: ex_result = lo;
         default: ex_result = 32'd0;
      endcase
   end

endmodule

// File: tb/tb_ex_stage.sv
// Directed bench for ex_stage with hand-computed expectations.
module tb_ex_stage;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        PIPELINE_FLUSH = 1'b0;
   logic        PIPELINE_READY = 1'b0;
   logic        PIPELINE_VALID;
   logic [4:0]  alu_op_i = '0;
   logic [31:0] src_a_i = '0, src_b_i = '0, rt_data_i = '0;
   logic        s_reg_write_i = 1'b0;
   logic [4:0]  s_reg_write_dst_i = '0;
   logic        s_mem_read_i = 1'b0, s_mem_write_i = 1'b0, s_mem_half_i = 1'b0;
   logic [31:0] ex_result, rt_bypass;
   logic        s_reg_write, s_mem_read, s_mem_write, s_mem_half;
   logic [4:0]  s_reg_write_dst;

   int tests = 0;
   int fails = 0;
   int n;

   ex_stage #(.DIV_CYCLES(32)) dut (
      .clk(clk), .rst_n(rst_n),
      .PIPELINE_FLUSH(PIPELINE_FLUSH), .PIPELINE_READY(PIPELINE_READY),
      .PIPELINE_VALID(PIPELINE_VALID),
      .alu_op_i(alu_op_i), .src_a_i(src_a_i), .src_b_i(src_b_i), .rt_data_i(rt_data_i),
      .s_reg_write_i(s_reg_write_i), .s_reg_write_dst_i(s_reg_write_dst_i),
      .s_mem_read_i(s_mem_read_i), .s_mem_write_i(s_mem_write_i), .s_mem_half_i(s_mem_half_i),
      .ex_result(ex_result), .rt_bypass(rt_bypass),
      .s_reg_write(s_reg_write), .s_mem_read(s_mem_read), .s_mem_write(s_mem_write),
      .s_mem_half(s_mem_half), .s_reg_write_dst(s_reg_write_dst)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] rt, input logic rw, input logic [4:0] dst,
                        input logic mr, input logic mw, input logic mh, input logic fl);
      alu_op_i = op; src_a_i = a; src_b_i = b; rt_data_i = rt;
      s_reg_write_i = rw; s_reg_write_dst_i = dst;
      s_mem_read_i = mr; s_mem_write_i = mw; s_mem_half_i = mh;
      PIPELINE_FLUSH = fl; PIPELINE_READY = 1'b1;
      @(posedge clk); #1;
      PIPELINE_READY = 1'b0; PIPELINE_FLUSH = 1'b0;
   endtask

   task automatic issue(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
      drive(op, a, b, 32'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic idle(input int cycles);
      for (int i = 0; i < cycles; i++) begin @(posedge clk); #1; end
   endtask

   // Counts edges until VALID rises; bounded so a stuck engine still ends the run.
   task automatic wait_valid(output int cycles);
      cycles = 0;
      while (!PIPELINE_VALID && cycles < 100) begin
         @(posedge clk); #1;
         cycles++;
      end
   endtask

   initial begin
      #12;
      chk("reset_valid", {31'd0, PIPELINE_VALID}, 32'd1);
      chk("reset_result", ex_result, 32'd0);
      chk("reset_ctrl", {26'd0, s_reg_write, s_reg_write_dst}, 32'd0);
      rst_n = 1'b1;
      @(posedge clk); #1;

      issue(5'd0, 32'h7FFF_FFFF, 32'd1);
      chk("add_wrap", ex_result, 32'h8000_0000);
      chk("add_valid", {31'd0, PIPELINE_VALID}, 32'd1);
      issue(5'd6, 32'hFFFF_FFFF, 32'd1);
      chk("slt_neg", ex_result, 32'd1);
      issue(5'd7, 32'd1, 32'hFFFF_FFFF);
      chk("sltu", ex_result, 32'd1);
      issue(5'd1, 32'd0, 32'd1);
      chk("sub_wrap", ex_result, 32'hFFFF_FFFF);
      issue(5'd5, 32'h0000_00F0, 32'h0000_000F);
      chk("nor", ex_result, 32'hFFFF_FF00);
      issue(5'd10, 32'd4, 32'hF000_0000);
      chk("sra", ex_result, 32'hFF00_0000);
      issue(5'd9, 32'd4, 32'hF000_0000);
      chk("srl", ex_result, 32'h0F00_0000);
      issue(5'd11, 32'd0, 32'h0000_1234);
      chk("lui", ex_result, 32'h1234_0000);
      issue(5'd25, 32'd3, 32'd4);
      chk("op_unused", ex_result, 32'd0);

      drive(5'd0, 32'd3, 32'd4, 32'hCAFE_F00D, 1'b1, 5'd7, 1'b1, 1'b0, 1'b1, 1'b0);
      chk("ctrl_result", ex_result, 32'd7);
      chk("ctrl_rt", rt_bypass, 32'hCAFE_F00D);
      chk("ctrl_fields", {24'd0, s_reg_write, s_reg_write_dst, s_mem_read, s_mem_write, s_mem_half},
          {24'd0, 1'b1, 5'd7, 1'b1, 1'b0, 1'b1});
      src_a_i = 32'd100; rt_data_i = 32'd0; s_reg_write_i = 1'b0;
      idle(2);
      chk("hold_result", ex_result, 32'd7);
      chk("hold_rw", {31'd0, s_reg_write}, 32'd1);

      issue(5'd18, 32'hFFFF_FFF9, 32'd2);
      chk("div_valid_low", {31'd0, PIPELINE_VALID}, 32'd0);
      wait_valid(n);
      chk("div_latency", n, 32'd32);
      issue(5'd13, 32'd0, 32'd0);
      chk("div_lo", ex_result, 32'hFFFF_FFFD);
      issue(5'd12, 32'd0, 32'd0);
      chk("div_hi", ex_result, 32'hFFFF_FFFF);

      issue(5'd19, 32'd5, 32'd0);
      wait_valid(n);
      chk("divz_latency", n, 32'd32);
      issue(5'd12, 32'd0, 32'd0);
      chk("divz_hi", ex_result, 32'd5);
      issue(5'd13, 32'd0, 32'd0);
      chk("divz_lo", ex_result, 32'hFFFF_FFFF);

      issue(5'd18, 32'h8000_0000, 32'hFFFF_FFFF);
      wait_valid(n);
      issue(5'd13, 32'd0, 32'd0);
      chk("divovf_lo", ex_result, 32'h8000_0000);
      issue(5'd12, 32'd0, 32'd0);
      chk("divovf_hi", ex_result, 32'd0);

      issue(5'd17, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
`ifdef EX_HW_MUL_EN
      chk("multu_valid", {31'd0, PIPELINE_VALID}, 32'd1);
`else
      chk("multu_valid_low", {31'd0, PIPELINE_VALID}, 32'd0);
      wait_valid(n);
      chk("multu_latency", n, 32'd32);
`endif
      issue(5'd12, 32'd0, 32'd0);
      chk("multu_hi", ex_result, 32'hFFFF_FFFE);
      issue(5'd13, 32'd0, 32'd0);
      chk("multu_lo", ex_result, 32'h0000_0001);

      issue(5'd16, 32'hFFFF_FFFD, 32'd5);
      wait_valid(n);
      issue(5'd12, 32'd0, 32'd0);
      chk("mult_hi", ex_result, 32'hFFFF_FFFF);
      issue(5'd13, 32'd0, 32'd0);
      chk("mult_lo", ex_result, 32'hFFFF_FFF1);

      issue(5'd14, 32'h11, 32'd0);
      issue(5'd12, 32'd0, 32'd0);
      chk("mthi_mfhi", ex_result, 32'h11);
      issue(5'd15, 32'h11, 32'd0);
      issue(5'd18, 32'd100, 32'd7);
      idle(5);
      chk("abort_busy", {31'd0, PIPELINE_VALID}, 32'd0);
      drive(5'd18, 32'd9, 32'd3, 32'd0, 1'b1, 5'd3, 1'b0, 1'b0, 1'b0, 1'b1);
      chk("abort_valid", {31'd0, PIPELINE_VALID}, 32'd1);
      chk("abort_rw", {31'd0, s_reg_write}, 32'd0);
      idle(40);
      chk("abort_idle", {31'd0, PIPELINE_VALID}, 32'd1);
      issue(5'd12, 32'd0, 32'd0);
      chk("abort_hi", ex_result, 32'h11);
      issue(5'd13, 32'd0, 32'd0);
      chk("abort_lo", ex_result, 32'h11);

      drive(5'd18, 32'd50, 32'd3, 32'h1234_5678, 1'b1, 5'd9, 1'b0, 1'b1, 1'b0, 1'b0);
      idle(5);
      rst_n = 1'b0;
      #1;
      chk("rst_valid", {31'd0, PIPELINE_VALID}, 32'd1);
      chk("rst_result", ex_result, 32'd0);
      chk("rst_rt", rt_bypass, 32'd0);
      chk("rst_ctrl", {24'd0, s_reg_write, s_reg_write_dst, s_mem_read, s_mem_write, s_mem_half}, 32'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      issue(5'd12, 32'd0, 32'd0);
      chk("rst_hi", ex_result, 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/ex_stage.md
Name: ex_stage

Overview:
- Execute stage of the 5-stage pipeline. Sits between decode and MEM.
- Registers decode outputs on the global pipeline handshake and computes single-cycle ALU results.
- Runs multi-cycle MULT/DIV into architectural HI/LO. Holds PIPELINE_VALID low until the result is ready.
- Feeds MEM: ex_result (address or ALU data), rt_bypass (store data) and the forwarded register-write and memory-control fields.

Parameters:
- DIV_CYCLES, 32: iterations of the radix-2 restoring divider. Fixed at 32; the parameter exists for bench visibility only.

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- PIPELINE_FLUSH  in  1  squash the instruction being latched (qualified by PIPELINE_READY)
- PIPELINE_READY  in  1  global advance; all stages latch when high
- PIPELINE_VALID  out  1  this stage's result is complete
- alu_op_i  in  5  operation code, see Behaviour
- src_a_i  in  32  operand A (rs, or shamt zero-extended for shifts)
- src_b_i  in  32  operand B (rt or immediate)
- rt_data_i  in  32  rt value for stores
- s_reg_write_i  in  1  destination write enable
- s_reg_write_dst_i  in  5  destination register
- s_mem_read_i, s_mem_write_i, s_mem_half_i  in  1 each  memory control
- ex_result  out  32  ALU / address result
- rt_bypass  out  32  latched rt_data
- s_reg_write, s_mem_read, s_mem_write, s_mem_half  out  1 each  latched control
- s_reg_write_dst  out  5  latched destination

Behaviour:
- Reset (async, rst_n=0): all input latches, HI, LO, state and counters are 0. All outputs are 0; PIPELINE_VALID=1 (a NOP is complete).
- Latch rules, on the rising edge:
  - READY&FLUSH: control latches (reg_write, dst, mem_*) and op are cleared to NOP (op 0). Any in-flight MULT/DIV is aborted and HI/LO stay unchanged.
  - READY only: all inputs latch.
  - READY low: all latches hold.
- Op codes:
  - 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 NOR
  - 6 SLT (signed), 7 SLTU
  - 8 SLL, 9 SRL, 10 SRA: shift amount is A[4:0], shifted value is B
  - 11 LUI: {B[15:0],16'h0}
  - 12 MFHI, 13 MFLO, 14 MTHI (HI<=A), 15 MTLO (LO<=A)
  - 16 MULT, 17 MULTU, 18 DIV, 19 DIVU
  - 20-31: result 0
- ADD/SUB wrap modulo 2^32 with no trap (see Optional Feature). ex_result is combinational from the latched operands. Single-cycle ops: PIPELINE_VALID=1 in the cycle after latch.
- MTHI/MTLO write HI/LO on the first clock edge after the op is latched. MFHI/MFLO read the current HI/LO, so a MTHI followed by MFHI returns the new value.
- FSM states IDLE, BUSY, DONE:
  - IDLE: a latched op 16-19 enters BUSY with cnt=0 and PIPELINE_VALID=0.
  - BUSY: one iteration per cycle, cnt++. When cnt=DIV_CYCLES-1, HI/LO are written once and the FSM moves to DONE.
  - DONE: PIPELINE_VALID=1, ex_result=0. READY latches the next op; the FSM returns to IDLE, or goes straight to BUSY if the next op is 16-19.
- Latency: a MULT/DIV latched at edge E gives PIPELINE_VALID=1 from edge E+DIV_CYCLES; the first rising edge of clk after E is E+1.
- MULT: signed 64-bit product; HI=upper word, LO=lower word. MULTU: unsigned product.
- DIV/DIVU: LO=quotient, HI=remainder.
  - Signed division works on magnitudes; the quotient is negated if the operand signs differ, and the remainder takes the dividend's sign.
  - Divide by zero: LO=32'hFFFFFFFF, HI=dividend. Same latency.
  - DIV 32'h80000000 / -1: LO=32'h80000000, HI=0.
- MFHI/MFLO issued while BUSY cannot occur: PIPELINE_READY is low while this stage is not valid.
- Reset mid-operation: aborts immediately and HI/LO=0.

Optional Feature:
- Macro: EX_HW_MUL_EN.
- Defined: MULT/MULTU use a combinational 32x32 multiplier. HI/LO are written on the first edge after latch and PIPELINE_VALID=1 immediately, i.e. a single-cycle op with no BUSY state. DIV is unchanged.
- Undefined: MULT/MULTU use an iterative shift-add over DIV_CYCLES cycles through the same FSM and counter, with signed handling by magnitude and sign fix.

Test Plan:
- ADD 0x7FFFFFFF+1 and SLT -1<1 (READY=1) -> ex_result 0x80000000, then 0x00000001. VALID stays 1.
- SRA A=4, B=0xF0000000 and LUI B=0x1234 -> 0xFF000000, then 0x12340000.
- DIV A=-7, B=2 -> VALID=0 for 32 cycles, then LO=0xFFFFFFFD, HI=0xFFFFFFFF. Follow with MFLO -> ex_result 0xFFFFFFFD.
- DIVU A=5, B=0, then DIV 0x80000000/-1 -> HI=5, LO=0xFFFFFFFF; then LO=0x80000000, HI=0.
- MULTU 0xFFFFFFFF*0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001. With EX_HW_MUL_EN the result appears with no VALID drop; without it, VALID is low for 32 cycles.
- Abort cases:
  - FLUSH with READY during BUSY (HI=LO=0x11 beforehand) -> FSM IDLE, HI/LO still 0x11, s_reg_write=0.
  - rst_n low mid-DIV -> all outputs 0 and VALID=1 asynchronously.
